// File: rtl/gray_conv_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : gray_conv_arbiter_pkg                                        |
// | Brief  : Shared defaults and the clog2 helper for the Gray converter  |
// |          arbiter slice.                                               |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
package gray_conv_arbiter_pkg;

  localparam int c_default_n_req = 4;
  localparam int c_default_width = 4;

  // Ceiling log2; used to size the requester index.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int c_default_id_w = clog2(c_default_n_req);

endpackage
`default_nettype wire

// File: rtl/gray_conv_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : gray_conv_arbiter_if                                         |
// | Brief  : Requester and result bundle for gray_conv_arbiter.           |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
interface gray_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] gray_in;
  logic [N_REQ-1:0]       ack;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_bin;
  logic [ID_W-1:0]        out_id;
  logic                   busy;

  // Requesters plus the result consumer.
  modport master (
    output req, gray_in, out_ready,
    input  ack, out_valid, out_bin, out_id, busy
  );

  // The shared converter.
  modport slave (
    input  req, gray_in, out_ready,
    output ack, out_valid, out_bin, out_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/gray_conv_arbiter_gray2bin_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : gray2bin_core                                                |
// | Brief  : Combinational Gray-to-binary converter. Each binary bit is   |
// |          the XOR of the Gray bits at and above its position.          |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module gray2bin_core #(
  parameter int WIDTH = 4
) (
  input  wire logic [WIDTH-1:0] gray,
  output logic      [WIDTH-1:0] bin
);

  // Shifting right zero-fills, so the reduction XOR covers exactly bits k..WIDTH-1.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    assign bin[k] = ^(gray >> k);
  end

endmodule
`default_nettype wire

// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : gray_conv_arbiter                                            |
// | Brief  : Round-robin sharing of one Gray-to-binary converter between  |
// |          N_REQ requesters, with a registered, tagged result stage.    |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int N_REQ = c_default_n_req,
  parameter int WIDTH = c_default_width,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  wire logic clk,
  input  wire logic rst,
  gray_conv_arbiter_if.slave bus
);

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_bin;
  logic [ID_W-1:0]  r_out_id;

  logic [ID_W-1:0]  w_grant;
  logic [ID_W-1:0]  w_grant_next;
  logic [ID_W:0]    w_idx;
  logic             w_found;
  logic             w_accept;
  logic [WIDTH-1:0] w_gray_sel;
  logic [WIDTH-1:0] w_bin;

  // A word is taken whenever someone asks and the result slot is free or draining.
  assign w_accept = (|bus.req) & (~r_out_valid | bus.out_ready) & ~rst;

  // Round-robin search starting at rr_ptr; wrap handled by explicit subtraction
  // so non-power-of-2 requester counts never produce an out-of-range index.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N_REQ)) w_idx = w_idx - (ID_W+1)'(N_REQ);
      if (!w_found && bus.req[w_idx[ID_W-1:0]]) begin
        w_grant = w_idx[ID_W-1:0];
        w_found = 1'b1;
      end
    end
  end

  assign w_grant_next = (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;

  // N_REQ:1 mux selecting the granted requester's word.
  always_comb begin
    w_gray_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == ID_W'(i)) w_gray_sel = bus.gray_in[i*WIDTH +: WIDTH];
    end
  end

  gray2bin_core #(.WIDTH(WIDTH)) u_core (
    .gray (w_gray_sel),
    .bin  (w_bin)
  );

  // One-hot acknowledge to the granted requester, only in an accept cycle.
  always_comb begin
    bus.ack = '0;
    if (w_accept) bus.ack[w_grant] = 1'b1;
  end

  // Result register and round-robin pointer; a simultaneous drain and load
  // simply overwrites the slot, keeping one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_bin   <= w_bin;
      r_out_id    <= w_grant;
      r_rr_ptr    <= w_grant_next;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_id    = r_out_id;
  assign bus.busy      = r_out_valid | (|bus.req);

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_gray_conv_arbiter                                         |
// | Brief  : Self-checking bench: directed scenarios plus randomized      |
// |          traffic compared cycle by cycle against a behavioural model. |
// | Rev    : 1.0  initial release                                         |
// +----------------------------------------------------------------------+
module tb_gray_conv_arbiter;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  gray_conv_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IDW)) bus ();

  gray_conv_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Binary value whose Gray encoding (b ^ b>>1) equals g.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    g2b = '0;
    for (int v = 0; v < (1 << W); v++) begin
      b = W'(v);
      if ((b ^ (b >> 1)) == g) g2b = b;
    end
  endfunction

  // ---------------- behavioural model ----------------
  int           m_valid = 0;
  int           m_bin   = 0;
  int           m_id    = 0;
  int           m_rr    = 0;
  logic [N-1:0] m_last_ack = '0;
  int           m_grant;
  int           m_acc;
  logic [N-1:0] e_ack;

  always @(negedge clk) begin
    m_acc   = ((|bus.req) && (!m_valid || bus.out_ready) && !rst) ? 1 : 0;
    m_grant = -1;
    for (int k = 0; k < N; k++) begin
      if (m_grant < 0 && bus.req[(m_rr + k) % N]) m_grant = (m_rr + k) % N;
    end
    e_ack = '0;
    if (m_acc != 0) e_ack[m_grant] = 1'b1;

    check("ack",       32'(bus.ack),       32'(e_ack));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_bin",   32'(bus.out_bin),   32'(m_bin));
    check("out_id",    32'(bus.out_id),    32'(m_id));
    check("busy",      32'(bus.busy),      32'((m_valid != 0) || (|bus.req)));

    if (rst) begin
      m_valid = 0; m_bin = 0; m_id = 0; m_rr = 0;
    end else if (m_acc != 0) begin
      m_bin   = int'(g2b(bus.gray_in[m_grant*W +: W]));
      m_id    = m_grant;
      m_valid = 1;
      m_rr    = (m_grant + 1) % N;
    end else if (m_valid != 0 && bus.out_ready) begin
      m_valid = 0;
    end
    m_last_ack = e_ack;
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0]   dreq;
  logic [W-1:0]   dword [N];
  logic [W-1:0]   w2;
  int             order [6] = '{0, 1, 2, 3, 0, 1};
  int             acc_cnt;
  bit             hit3;

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.gray_in = '0;
    bus.out_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    // Single request from requester 0.
    bus.req = 4'b0001;
    bus.gray_in[0 +: W] = 4'b1101;
    #1 check("t1_ack", 32'(bus.ack), 32'h1);
    cyc();
    bus.req = '0;
    #1;
    check("t1_valid", 32'(bus.out_valid), 32'h1);
    check("t1_bin",   32'(bus.out_bin),   32'b1001);
    check("t1_id",    32'(bus.out_id),    32'h0);

    // Requester 2 streams all 16 codes back to back.
    for (int g = 0; g < 16; g++) begin
      bus.req = 4'b0100;
      bus.gray_in[2*W +: W] = W'(g);
      cyc();
      check("t2_valid", 32'(bus.out_valid), 32'h1);
      if (g == 8) check("t2_1000", 32'(bus.out_bin), 32'b1111);
      if (g == 6) check("t2_0110", 32'(bus.out_bin), 32'b0100);
      if (g == 0) check("t2_0000", 32'(bus.out_bin), 32'b0000);
    end
    bus.req = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // All four requesting continuously: rotation 0,1,2,3,0,1.
    for (int i = 0; i < N; i++) bus.gray_in[i*W +: W] = W'($urandom);
    bus.req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1 check("t3_ack", 32'(bus.ack), 32'(1 << order[c]));
      if (c > 0) check("t3_id", 32'(bus.out_id), 32'(order[c-1]));
      cyc();
    end
    check("t3_id_last", 32'(bus.out_id), 32'h1);

    // Backpressure with requester 2 waiting.
    bus.out_ready = 1'b0;
    bus.req = 4'b0100;
    w2 = 4'b1011;
    bus.gray_in[2*W +: W] = w2;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t4_ack_blocked", 32'(bus.ack), 32'h0);
      check("t4_id_held",     32'(bus.out_id), 32'h1);
      check("t4_valid_held",  32'(bus.out_valid), 32'h1);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1 check("t4_ack_release", 32'(bus.ack), 32'b0100);
    cyc();
    check("t4_id_new",  32'(bus.out_id),  32'h2);
    check("t4_bin_new", 32'(bus.out_bin), 32'b1101);

    // Reset while holding a result; req=1010 pending.
    bus.req = 4'b1010;
    rst = 1'b1;
    #1 check("t5_ack_in_rst", 32'(bus.ack), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("t5_valid", 32'(bus.out_valid), 32'h0);
    check("t5_bin",   32'(bus.out_bin),   32'h0);
    check("t5_ack",   32'(bus.ack),       32'b0010);
    cyc();
    check("t5_id", 32'(bus.out_id), 32'h1);

    // Fairness: requester 3 held, requester 0 toggling.
    for (int r = 0; r < 3; r++) begin
      acc_cnt = 0;
      hit3 = 1'b0;
      for (int c = 0; c < 16 && !hit3; c++) begin
        bus.req = {1'b1, 2'b00, 1'(c % 2)};
        #1;
        if (|bus.ack) acc_cnt++;
        if (bus.ack[3]) hit3 = 1'b1;
        cyc();
      end
      check("t6_fair", 32'(hit3 && acc_cnt <= N), 32'h1);
    end

    // Request withdrawn before ack yields no result.
    bus.out_ready = 1'b0;
    bus.req = 4'b0010;
    #1 check("t6_drop_ack", 32'(bus.ack), 32'h0);
    cyc();
    bus.req = '0;
    bus.out_ready = 1'b1;
    cyc();
    check("t6_drop_valid", 32'(bus.out_valid), 32'h0);

    // Randomized traffic; the model process checks every cycle.
    dreq = '0;
    for (int i = 0; i < N; i++) dword[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_last_ack[i] || !dreq[i]) begin
          dreq[i]  = ($urandom % 3) != 0;
          dword[i] = W'($urandom);
        end else if ($urandom % 16 == 0) begin
          dreq[i] = 1'b0;
        end
        bus.gray_in[i*W +: W] = dword[i];
      end
      bus.req       = dreq;
      bus.out_ready = ($urandom % 4) != 0;
      rst           = ($urandom % 256) == 0;
      cyc();
    end

    rst = 1'b0;
    bus.req = '0;
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
